// File: rtl/reg_bank_rw.sv
// General-purpose register bank: one write port, two registered read ports with
// same-edge write-to-read bypass. $0 is hardwired to zero; the stack pointer resets to SP_RESET.
module reg_bank_rw #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wr_busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_accept;
  logic              wr_busy_q;
  logic [ADDR_W-1:0] rd_addr   [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic [DATA_W-1:0] rd_data_q [2];

  // Writes to $0 are dropped here, so $0 never leaves its reset value of zero.
  assign wr_accept = reg_write && (write_reg != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (wr_accept) begin
      regs_q[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_busy_q <= 1'b0;
    end else begin
      wr_busy_q <= wr_accept;
    end
  end

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      // Bypass the write landing on this same edge so a write-back-cycle read sees the new value.
      always_comb begin
        rd_data_d[gi] = regs_q[rd_addr[gi]];
        if (wr_accept && (write_reg == rd_addr[gi])) begin
          rd_data_d[gi] = write_data;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_data_q[gi] <= '0;
        end else begin
          rd_data_q[gi] <= rd_data_d[gi];
        end
      end
    end
  endgenerate

  assign read_data1 = rd_data_q[0];
  assign read_data2 = rd_data_q[1];
  assign wr_busy    = wr_busy_q;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Self-checking bench for reg_bank_rw: directed scenarios followed by random traffic,
// all compared against an array-based model of the register file.
module tb_reg_bank_rw;

  logic        clk;
  logic        reset_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        wr_busy;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  logic [31:0] model_mem [32];

  reg_bank_rw #(
    .DATA_W(32), .ADDR_W(5), .SP_INDEX(29), .SP_RESET(227)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wr_busy    (wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
    model_mem[29] = 32'd227;
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
    reg_write = we; write_reg = wa; write_data = wd; read_reg1 = ra1; read_reg2 = ra2;
  endtask

  // One clock edge: predict from the current inputs, then compare just after the edge.
  task automatic step(input string tag);
    logic        accept;
    logic [31:0] exp1, exp2;
    accept = reg_write && (write_reg != 5'd0);
    exp1 = (accept && write_reg == read_reg1) ? write_data : model_mem[read_reg1];
    exp2 = (accept && write_reg == read_reg2) ? write_data : model_mem[read_reg2];
    @(posedge clk); #1;
    check_eq({tag, ".rd1"}, read_data1, exp1);
    check_eq({tag, ".rd2"}, read_data2, exp2);
    check_eq({tag, ".busy"}, {31'd0, wr_busy}, {31'd0, accept});
    if (accept) model_mem[write_reg] = write_data;
    $display("step %s we=%0b wa=%0d wd=%08h ra1=%0d ra2=%0d -> rd1=%08h rd2=%08h busy=%0b",
             tag, reg_write, write_reg, write_data, read_reg1, read_reg2,
             read_data1, read_data2, wr_busy);
  endtask

  // Called #1 after an edge: asserts reset mid-cycle, checks outputs clear at once, releases mid-cycle.
  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check_eq({tag, ".rst_rd1"}, read_data1, 32'd0);
    check_eq({tag, ".rst_rd2"}, read_data2, 32'd0);
    check_eq({tag, ".rst_busy"}, {31'd0, wr_busy}, 32'd0);
    model_reset();
    @(posedge clk); #3;
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    check_eq({tag, ".rel_busy"}, {31'd0, wr_busy}, 32'd0);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    pulse_reset("init");

    set_in(1'b0, 5'd0, 32'd0, 5'd29, 5'd0);             step("sp_reset");
    check_eq("sp_reset_abs", read_data1, 32'd227);

    set_in(1'b1, 5'd8, 32'h0000_00AB, 5'd1, 5'd2);      step("wr8");
    set_in(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);              step("rd8");
    check_eq("rd8_abs", read_data1, 32'h0000_00AB);

    set_in(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);      step("wr0");
    check_eq("wr0_abs", read_data1, 32'd0);
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd8);              step("rd0");

    set_in(1'b1, 5'd9, 32'd5, 5'd0, 5'd0);              step("wr9a");
    set_in(1'b1, 5'd9, 32'd7, 5'd9, 5'd9);              step("byp9");
    check_eq("byp9_abs", read_data2, 32'd7);
    set_in(1'b0, 5'd9, 32'd0, 5'd9, 5'd9);              step("hold9");

    set_in(1'b1, 5'd10, 32'd1, 5'd0, 5'd0);             step("b2b1");
    set_in(1'b1, 5'd11, 32'd2, 5'd0, 5'd0);             step("b2b2");
    set_in(1'b1, 5'd10, 32'd3, 5'd0, 5'd0);             step("b2b3");
    set_in(1'b0, 5'd0, 32'd0, 5'd10, 5'd11);            step("b2bchk");
    check_eq("b2b_abs", read_data1 + read_data2, 32'd5);

    set_in(1'b1, 5'd29, 32'd100, 5'd0, 5'd0);           step("wr29");
    set_in(1'b1, 5'd12, 32'h1234_5678, 5'd0, 5'd0);
    pulse_reset("midwr");
    set_in(1'b0, 5'd0, 32'd0, 5'd29, 5'd12);            step("post_rst");
    check_eq("post_rst_abs", read_data1, 32'd227);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] pick [4];
      pick[0] = 5'd0; pick[1] = 5'd9; pick[2] = 5'd29; pick[3] = 5'd31;
      set_in(1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 3)] : 5'($urandom_range(0, 31)),
             $urandom(),
             ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 3)] : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 3)] : 5'($urandom_range(0, 31)));
      step("rnd");
      if (n == 200) pulse_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
